// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads Ins_mem, queues {pc, word} in a FWFT buffer for decode.
// Latency: a word pushed on an edge is at the head the following cycle; after a redirect edge the new PC is
// presented next cycle and its word is at the head one cycle later. Backpressure: the queue fills while
// inst_ready is low and fetch stalls, holding imem_addr. Optional halt detect: INSTR_FETCH_HALT_DET_EN.
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetch_cnt,
  output logic              halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] q_pc  [DEPTH];
  logic [DATA_W-1:0] q_dat [DEPTH];
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic [CW-1:0]     count;
  logic              fetching;
  logic              head_vld;
  logic              push;
  logic              pop;

  // Fullness uses the start-of-cycle count, so a same-cycle pop never frees a slot for a push.
  assign head_vld = (count != '0);
  assign push     = fetching && (count < CW'(DEPTH)) && !redirect_valid;
  assign pop      = head_vld && inst_ready && !redirect_valid;

`ifdef INSTR_FETCH_HALT_DET_EN
  typedef enum logic {S_FETCH, S_HALT} state_t;
  state_t state;

  // Enter HALT when an all-ones word is pushed; only a redirect (or reset) resumes fetching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else if (redirect_valid) begin
      state <= S_FETCH;
    end else if (push && (imem_data == {DATA_W{1'b1}})) begin
      state <= S_HALT;
    end
  end

  assign fetching = (state == S_FETCH);
  assign halted   = (state == S_HALT);
`else
  assign fetching = 1'b1;
  assign halted   = 1'b0;
`endif

  // Fetch PC, pointers, occupancy and push counter; a redirect discards the queue contents wholesale.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc       <= RESET_PC;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      fetch_cnt <= '0;
    end else if (redirect_valid) begin
      fpc   <= redirect_pc;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr      <= wptr + PW'(1);
        fpc       <= fpc + ADDR_W'(1);
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: contents are only visible through the valid-gated head, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wptr]  <= fpc;
      q_dat[wptr] <= imem_data;
    end
  end

  assign imem_addr  = fpc;
  assign inst_valid = head_vld;
  assign inst_data  = head_vld ? q_dat[rptr] : '0;
  assign inst_pc    = head_vld ? q_pc[rptr]  : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed phases against a queue-based reference model.
// The model tracks the fetch PC and a FIFO of {pc, word}; outputs are compared every cycle.
// A few literal expectations per phase pin the model to hand-derived values.
module tb_instr_fetch;

`ifdef INSTR_FETCH_HALT_DET_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic        inst_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] fetch_cnt;
  logic        halted;

  int errors = 0;
  int checks = 0;
  bit halt_word = 1'b0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_cnt      (fetch_cnt),
    .halted         (halted)
  );

  // Instruction memory: word[i] = 0x1000_0000 + i, with word[5] = all ones when halt_word is set.
  assign imem_data = (halt_word && imem_addr == 16'd5) ? 32'hFFFF_FFFF
                                                       : 32'h1000_0000 + {16'h0000, imem_addr};

  function automatic logic [31:0] word(input logic [15:0] a);
    if (halt_word && a == 16'd5) return 32'hFFFF_FFFF;
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_fpc = 16'h0000;
  logic [15:0] m_cnt = 16'h0000;
  bit          m_halt = 1'b0;

  // Reference model: queue semantics straight from the fetch rules.
  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst) begin
      mq.delete();
      m_fpc  = 16'h0000;
      m_cnt  = 16'h0000;
      m_halt = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      m_fpc  = redirect_pc;
      m_halt = 1'b0;
    end else begin
      do_push = !m_halt && (mq.size() < 4);
      do_pop  = (mq.size() > 0) && inst_ready;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({m_fpc, word(m_fpc)});
        if (HALT_EN && word(m_fpc) == 32'hFFFF_FFFF) m_halt = 1'b1;
        m_fpc = m_fpc + 16'd1;
        m_cnt = m_cnt + 16'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!done) begin
      logic        ev;
      logic [31:0] ed;
      logic [15:0] ep;
      ev = (mq.size() > 0);
      ed = ev ? mq[0].dat : 32'h0;
      ep = ev ? mq[0].pc  : 16'h0;
      chk("model_valid", {31'b0, inst_valid}, {31'b0, ev});
      chk("model_data", inst_data, ed);
      chk("model_pc", {16'h0, inst_pc}, {16'h0, ep});
      chk("model_addr", {16'h0, imem_addr}, {16'h0, m_fpc});
      chk("model_fcnt", {16'h0, fetch_cnt}, {16'h0, m_cnt});
      chk("model_halted", {31'b0, halted}, {31'b0, m_halt});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    cycles(2);
    chk("rst_addr",   {16'h0, imem_addr}, 32'h0);
    chk("rst_valid",  {31'b0, inst_valid}, 32'h0);
    chk("rst_data",   inst_data, 32'h0);
    chk("rst_pc",     {16'h0, inst_pc}, 32'h0);
    chk("rst_fcnt",   {16'h0, fetch_cnt}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    // Streaming after reset release: three edges give head pc 2.
    rst = 1'b0;
    cycles(1);
    chk("first_pc", {16'h0, inst_pc}, 32'h0);
    chk("first_data", inst_data, 32'h1000_0000);
    cycles(2);
    chk("stream_pc", {16'h0, inst_pc}, 32'h2);
    chk("stream_data", inst_data, 32'h1000_0002);
    chk("stream_fcnt", {16'h0, fetch_cnt}, 32'h3);

    // Backpressure from a fresh reset: exactly four pushes, address holds at 4.
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    inst_ready = 1'b0;
    cycles(10);
    chk("full_addr", {16'h0, imem_addr}, 32'h4);
    chk("full_fcnt", {16'h0, fetch_cnt}, 32'h4);
    chk("full_pc", {16'h0, inst_pc}, 32'h0);
    inst_ready = 1'b1;
    cycles(1);
    chk("drain1_pc", {16'h0, inst_pc}, 32'h1);
    chk("drain1_addr", {16'h0, imem_addr}, 32'h4);
    cycles(3);
    chk("drain4_pc", {16'h0, inst_pc}, 32'h4);
    chk("drain4_fcnt", {16'h0, fetch_cnt}, 32'h7);

    // Redirect with three entries queued and the consumer ready.
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    cycles(1);
    redirect_valid = 1'b0;
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    chk("redir_addr", {16'h0, imem_addr}, 32'h0100);
    cycles(1);
    chk("redir_head", {16'h0, inst_pc}, 32'h0100);
    chk("redir_data", inst_data, 32'h1000_0100);

    // PC wrap across 0xFFFF.
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    cycles(1);
    redirect_valid = 1'b0;
    cycles(1);
    chk("wrap0", {16'h0, inst_pc}, 32'hFFFE);
    cycles(1);
    chk("wrap1", {16'h0, inst_pc}, 32'hFFFF);
    cycles(1);
    chk("wrap2", {16'h0, inst_pc}, 32'h0000);
    chk("wrap2_data", inst_data, 32'h1000_0000);
    cycles(1);
    chk("wrap3", {16'h0, inst_pc}, 32'h0001);

    // Reset with the queue full.
    inst_ready = 1'b0;
    cycles(6);
    rst = 1'b1;
    cycles(1);
    chk("rst2_addr",  {16'h0, imem_addr}, 32'h0);
    chk("rst2_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst2_fcnt",  {16'h0, fetch_cnt}, 32'h0);
    rst = 1'b0;
    cycles(1);
    chk("rst2_head", {16'h0, inst_pc}, 32'h0);

    // All-ones word at pc 5.
    rst = 1'b1;
    cycles(1);
    halt_word = 1'b1;
    rst = 1'b0;
    inst_ready = 1'b1;
    cycles(6);
    chk("hw_pc5", {16'h0, inst_pc}, 32'h5);
    chk("hw_data5", inst_data, 32'hFFFF_FFFF);
    cycles(2);
    if (HALT_EN) begin
      chk("halt_flag", {31'b0, halted}, 32'h1);
      chk("halt_addr", {16'h0, imem_addr}, 32'h6);
      chk("halt_valid", {31'b0, inst_valid}, 32'h0);
    end else begin
      chk("nohalt_flag", {31'b0, halted}, 32'h0);
      chk("nohalt_addr", {16'h0, imem_addr}, 32'h8);
      chk("nohalt_pc", {16'h0, inst_pc}, 32'h7);
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    cycles(1);
    redirect_valid = 1'b0;
    chk("resume_halted", {31'b0, halted}, 32'h0);
    chk("resume_addr", {16'h0, imem_addr}, 32'h0);
    cycles(1);
    chk("resume_head", {16'h0, inst_pc}, 32'h0);

    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
